negedge_capture_serial_tx: RTL



---
 rtl/negedge_capture_serial_tx.sv | 103 ++++++++++
 1 files changed

// File: rtl/negedge_capture_serial_tx.sv
// Parallel-in, serial-out transmitter: launches MSB-first bits on the rising edge with a framing strobe,
// for a falling-edge-sampling receiver. Define NEGEDGE_SERIAL_TX_PARITY_EN to append an even-parity cell.
module negedge_capture_serial_tx #(
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic [WIDTH-1:0] DIN,
    input  logic             VALID,
    output logic             READY,
    output logic             SDO,
    output logic             SFRAME,
    output logic             BUSY
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP_ST,
        PARITY
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [CW-1:0]    bit_cnt_reg;
    logic [3:0]       gap_cnt_reg;
`ifdef NEGEDGE_SERIAL_TX_PARITY_EN
    logic             par_reg;
`endif

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            gap_cnt_reg <= '0;
`ifdef NEGEDGE_SERIAL_TX_PARITY_EN
            par_reg     <= 1'b0;
`endif
            SDO         <= 1'b0;
            SFRAME      <= 1'b0;
            BUSY        <= 1'b0;
            READY       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // READY only rises one edge after reset release, so VALID held
                    // through reset cannot be accepted early.
                    if (READY && VALID) begin
                        shift_reg   <= DIN;
`ifdef NEGEDGE_SERIAL_TX_PARITY_EN
                        par_reg     <= ^DIN;
`endif
                        SDO         <= DIN[WIDTH-1];
                        SFRAME      <= 1'b1;
                        READY       <= 1'b0;
                        BUSY        <= 1'b1;
                        bit_cnt_reg <= CW'(WIDTH - 1);
                        state_reg   <= SHIFT;
                    end else begin
                        READY <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (bit_cnt_reg != '0) begin
                        shift_reg   <= shift_reg << 1;
                        SDO         <= shift_reg[WIDTH-2];
                        bit_cnt_reg <= bit_cnt_reg - 1'b1;
                    end else begin
`ifdef NEGEDGE_SERIAL_TX_PARITY_EN
                        SDO         <= par_reg;
                        state_reg   <= PARITY;
`else
                        SDO         <= 1'b0;
                        SFRAME      <= 1'b0;
                        gap_cnt_reg <= 4'(GAP);
                        state_reg   <= GAP_ST;
`endif
                    end
                end
                PARITY: begin
                    SDO         <= 1'b0;
                    SFRAME      <= 1'b0;
                    gap_cnt_reg <= 4'(GAP);
                    state_reg   <= GAP_ST;
                end
                GAP_ST: begin
                    if (gap_cnt_reg <= 4'd1) begin
                        gap_cnt_reg <= 4'd0;
                        READY       <= 1'b1;
                        BUSY        <= 1'b0;
                        state_reg   <= IDLE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg - 4'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
